// File: rtl/mem_pkg.sv
// Shared types for the memory responder: access sizes, FSM states and
// the size-to-byte-count helper.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Reserved size maps to 4 so the range check stays well defined
    function automatic logic [2:0] size_bytes(input mem_size_e s);
        unique case (s)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator (master)
// and the memory responder (slave).
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_byte_store.sv
// Single-port byte-wide storage: synchronous write, asynchronous read,
// contents are never reset.
module mem_byte_store #(
    parameter int DEPTH_BYTES = 'h10000,
    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] r_mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= din;
    end

    assign dout = r_mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Byte-serial little-endian memory responder with valid/ready request and
// response channels. Define MEM_RESP_ALIGN_CHECK_EN to reject misaligned HALF/WORD.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 'h10000
) (
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    mem_state_e    r_state;
    mem_state_e    w_state_nx;
    logic          r_write;
    logic          r_uns;
    mem_size_e     r_size;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [1:0]    r_cnt;
    logic [1:0]    r_last;

    mem_size_e     w_size;
    logic [2:0]    w_n;
    logic [32:0]   w_end;
    logic          w_misal;
    logic          w_req_err;
    logic          w_accept;
    logic          w_last;
    logic          w_we;
    logic [AW-1:0] w_store_addr;
    logic [7:0]    w_din;
    logic [7:0]    w_dout;
    logic [31:0]   w_asm;
    logic [31:0]   w_ext;

    assign w_size = mem_size_e'(bus.req_size);
    assign w_n    = size_bytes(w_size);
    // 33-bit end address so a request near 2^32 cannot wrap into range
    assign w_end  = {1'b0, bus.req_addr} + 33'(w_n);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign w_misal = ((w_size == SZ_HALF) && bus.req_addr[0])
                  || ((w_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misal = 1'b0;
`endif

    assign w_req_err = (w_size == SZ_RSVD)
                    || (w_end > 33'(DEPTH_BYTES))
                    || w_misal;

    assign w_accept     = bus.req_valid && (r_state == IDLE);
    assign w_last       = (r_cnt == r_last);
    assign w_we         = (r_state == XFER) && r_write;
    assign w_store_addr = r_addr + AW'(r_cnt);
    assign w_din        = r_wdata[{r_cnt, 3'b000} +: 8];

    always_comb begin
        w_asm = r_rdata;
        w_asm[{r_cnt, 3'b000} +: 8] = w_dout;
    end

    always_comb begin
        w_ext = w_asm;
        unique case (r_size)
            SZ_BYTE: w_ext = r_uns ? {24'd0, w_asm[7:0]}
                                   : {{24{w_asm[7]}}, w_asm[7:0]};
            SZ_HALF: w_ext = r_uns ? {16'd0, w_asm[15:0]}
                                   : {{16{w_asm[15]}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nx = w_req_err ? RESP : XFER;
            XFER: if (w_last) w_state_nx = RESP;
            RESP: if (bus.resp_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_last  <= '0;
        end else if (w_accept) begin
            r_write <= bus.req_write;
            r_uns   <= bus.req_unsigned;
            r_size  <= w_size;
            r_addr  <= bus.req_addr[AW-1:0];
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_err   <= w_req_err;
            r_cnt   <= '0;
            r_last  <= 2'(w_n - 3'd1);
        end else if (r_state == XFER) begin
            r_cnt <= r_cnt + 2'd1;
            if (!r_write) r_rdata <= w_last ? w_ext : w_asm;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = (r_state == RESP) ? r_rdata : 32'd0;
    assign bus.resp_err   = (r_state == RESP) && r_err;

    mem_byte_store #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_store (
        .clk  (clk),
        .we   (w_we),
        .addr (w_store_addr),
        .din  (w_din),
        .dout (w_dout)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: loads, stores, range/size errors,
// response back-pressure and reset during a transfer.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 'h10000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_BYTES(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic w,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eer,
                        input int elat, input bit push);
        int   n;
        logic rdy;
        n = 0;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        do begin
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        chk({tag, "/acc_cycles"}, 32'(n), 32'd1);
        bus.req_valid = 1'b0;
        if (push) sb.push_back('{erd, eer, elat, tag});
    endtask

    task automatic take(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({e.tag, "/valid"}, 32'(bus.resp_valid), 32'd1);
        chk({e.tag, "/lat"}, 32'(lat), 32'(e.lat));
        chk({e.tag, "/rdata"}, bus.resp_rdata, e.rd);
        chk({e.tag, "/err"}, 32'(bus.resp_err), 32'(e.er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({e.tag, "/hold_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({e.tag, "/hold_rdata"}, bus.resp_rdata, e.rd);
            chk({e.tag, "/hold_err"}, 32'(bus.resp_err), 32'(e.er));
            chk({e.tag, "/hold_rdy"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk({e.tag, "/done_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({e.tag, "/done_rdy"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b0;

        #12;
        chk("rst/req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst/resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst/resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // resp_ready while idle has no effect
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("idle_rr/valid", 32'(bus.resp_valid), 32'd0);
        chk("idle_rr/rdy", 32'(bus.req_ready), 32'd1);

        send("pre_w100", 1, SZ_WORD, 0, 32'h100, 32'h07B00293, 0, 0, 5, 1);
        take(0);
        send("pre_b80", 1, SZ_BYTE, 0, 32'h80, 32'h00000088, 0, 0, 2, 1);
        take(0);
        send("pre_b104", 1, SZ_BYTE, 0, 32'h104, 32'h0000005A, 0, 0, 2, 1);
        take(0);
        send("pre_w300", 1, SZ_WORD, 0, 32'h300, 32'h0, 0, 0, 5, 1);
        take(0);

        send("ld_w100", 0, SZ_WORD, 0, 32'h100, 0, 32'h07B00293, 0, 5, 1);
        take(0);
        send("ld_b80s", 0, SZ_BYTE, 0, 32'h80, 0, 32'hFFFFFF88, 0, 2, 1);
        take(0);
        send("ld_b80u", 0, SZ_BYTE, 1, 32'h80, 0, 32'h00000088, 0, 2, 1);
        take(0);

        send("st_w200", 1, SZ_WORD, 0, 32'h200, 32'hDEADBEEF, 0, 0, 5, 1);
        take(0);
        send("ld_h202s", 0, SZ_HALF, 0, 32'h202, 0, 32'hFFFFDEAD, 0, 3, 1);
        take(0);
        send("ld_h200u", 0, SZ_HALF, 1, 32'h200, 0, 32'h0000BEEF, 0, 3, 1);
        take(0);

        send("err_w_top", 0, SZ_WORD, 0, 32'(DEPTH - 2), 0, 0, 1, 1, 1);
        take(0);
        send("err_sz3", 0, SZ_RSVD, 0, 32'h100, 0, 0, 1, 1, 1);
        take(0);
        send("err_wrap", 0, SZ_WORD, 0, 32'hFFFFFFFE, 0, 0, 1, 1, 1);
        take(0);
        send("err_st", 1, SZ_HALF, 0, 32'(DEPTH - 1), 32'h1234, 0, 1, 1, 1);
        take(0);
        send("st_last", 1, SZ_BYTE, 0, 32'(DEPTH - 1), 32'h7F, 0, 0, 2, 1);
        take(0);
        send("ld_last", 0, SZ_BYTE, 0, 32'(DEPTH - 1), 0, 32'h7F, 0, 2, 1);
        take(0);

        // Back-pressure with a pending request held by the initiator
        send("hold_ld", 0, SZ_WORD, 0, 32'h100, 0, 32'h07B00293, 0, 5, 1);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b0;
        bus.req_size     = SZ_BYTE;
        bus.req_unsigned = 1'b1;
        bus.req_addr     = 32'h80;
        take(10);
        send("after_hold", 0, SZ_BYTE, 1, 32'h80, 0, 32'h88, 0, 2, 1);
        take(0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
        send("mis_w101", 0, SZ_WORD, 0, 32'h101, 0, 0, 1, 1, 1);
`else
        send("mis_w101", 0, SZ_WORD, 0, 32'h101, 0, 32'h5A07B002, 0, 5, 1);
`endif
        take(0);

        // Reset after the second transfer edge of a word store
        send("rst_st", 1, SZ_WORD, 0, 32'h300, 32'hA1B2C3D4, 0, 0, 5, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort/req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort/resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort/resp_rdata", bus.resp_rdata, 32'd0);
        chk("abort/resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort/idle_after", 32'(bus.req_ready), 32'd1);
        chk("abort/no_resp", 32'(bus.resp_valid), 32'd0);
        send("ld_h300", 0, SZ_HALF, 1, 32'h300, 0, 32'h0000C3D4, 0, 3, 1);
        take(0);
        send("ld_h302", 0, SZ_HALF, 1, 32'h302, 0, 32'h00000000, 0, 3, 1);
        take(0);

        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's load/store/fetch traffic. It accepts one 32-bit-addressed request at a time over a valid/ready handshake and serves it byte-serially from an internal byte-wide store, little-endian. It returns read data sign- or zero-extended, or an error flag, over a second valid/ready handshake. It sits between the control FSM and storage, replacing direct combinational RAM access with a multi-cycle, back-pressurable interface.

## Interface
- DEPTH_BYTES, default 'h10000 — store size in bytes; valid addresses 0..DEPTH_BYTES-1
- clk  in  1  — clock, all state on posedge
- rst_n  in  1  — reset, asynchronous, active-low
- req_valid  in  1  — request present
- req_ready  out  1  — responder can accept; =1 exactly when state is IDLE
- req_write  in  1  — 1 = store, 0 = load/fetch
- req_size  in  2  — MemSize: BYTE=0, HALF=1, WORD=2, 3 reserved
- req_unsigned  in  1  — loads: 1 zero-extend, 0 sign-extend
- req_addr  in  32  — byte address of least significant byte
- req_wdata  in  32  — store data, low 8/16/32 bits used
- resp_valid  out  1  — response present
- resp_ready  in  1  — consumer takes response
- resp_rdata  out  32  — extended load data; 0 for stores and errors
- resp_err  out  1  — request rejected, no bytes accessed

## Operation
- States: IDLE, XFER, RESP.
- IDLE: when req_valid && req_ready, latch write, size, unsigned, addr, and wdata. Set byte counter to 0 and n = 1/2/4 for BYTE/HALF/WORD.
- Error check happens at acceptance. An error is raised for size 3, or for addr + n > DEPTH_BYTES (computed in 33 bits, so no wrap at 2^32). On error, go directly to RESP with resp_err=1 and resp_rdata=0. No store access occurs.
- Otherwise go to XFER. Each cycle transfers byte i = counter at address addr+i.
  - Load: assemble byte into rdata[8i +: 8].
  - Store: write wdata[8i +: 8].
- After byte n-1, go to RESP. Load data is extended from bit 8n-1 per req_unsigned. Stores return 0.
- RESP: hold resp_valid, resp_rdata, and resp_err stable until resp_ready is sampled high. Then go to IDLE with resp_valid=0.
- A request arriving while not in IDLE is not accepted (req_ready=0). The initiator holds it.
- Store contents are not reset and are initialised only by the bench.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Request accepted at edge T. Bytes are transferred at edges T+1 .. T+n. resp_valid is high after edge T+n.
- Minimum latency from acceptance to resp_valid: BYTE 2, HALF 3, WORD 5 cycles. Error responses: 1 cycle.
- Response handshake at edge R (resp_valid && resp_ready). req_ready=1 after R. The next request is accepted at R+1 at the earliest, giving no back-to-back overlap.
- Store write is synchronous on the XFER edge. Store read is combinational from the current address.
- Reset asserted mid-XFER aborts immediately. Bytes already written remain; the remaining bytes are not written. No response is produced.
- resp_ready asserted while resp_valid=0 is ignored.

## Configuration
- MEM_RESP_ALIGN_CHECK_EN defined: HALF with addr[0]≠0 or WORD with addr[1:0]≠0 is an error, handled like an out-of-range request.
- Undefined: misaligned accesses are legal and served byte-serially at addr..addr+n-1.

## Structure
- Package mem_pkg holds:
  - MemSize enum
  - MemState enum (IDLE, XFER, RESP)
  - a helper function mapping MemSize to byte count
- Sub-module mem_byte_store#(DEPTH_BYTES): single-port byte array with clk, we, addr, din[7:0], and dout[7:0]. Write is synchronous, read is asynchronous, and there is no reset.
- mem_responder contains the FSM, the 2-bit byte counter, the latched request, the rdata assembly, and the extension logic.

## Test plan
- Preload bytes 0x100..0x103 = 0x93,0x02,0xB0,0x07. WORD load at 0x100 -> resp_rdata=0x07B00293, resp_err=0, resp_valid 5 cycles after acceptance.
- Byte 0x80 holds 0x88. BYTE load at 0x80 signed -> 0xFFFFFF88; unsigned -> 0x00000088.
- WORD store 0xDEADBEEF at 0x200, then HALF signed load at 0x202 -> 0xFFFFDEAD. Store response shows rdata=0, err=0.
- WORD load at DEPTH_BYTES-2 -> resp_err=1, rdata=0, resp_valid 1 cycle after acceptance. Size 3 gives the same response.
- Hold resp_ready=0 for 10 cycles in RESP -> outputs stable, req_ready=0, a new req_valid is not accepted. Then take the response and accept the next request one cycle later.
- WORD store at 0x300 (old contents 0), rst_n pulsed low after the 2nd XFER edge -> bytes 0x300-0x301 written, 0x302-0x303 still 0, state=IDLE, resp_valid=0. With MEM_RESP_ALIGN_CHECK_EN defined, a WORD load at 0x101 -> resp_err=1.
